// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and ASCII constants for the hex streamer.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DONE} state_t;

    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_LA = 8'h61;
    localparam logic [7:0] ASC_UA = 8'h41;

endpackage

// File: rtl/hex_to_ascii.sv
// hex_to_ascii: combinational nibble to ASCII hex digit, case chosen by UPPER.
module hex_to_ascii
    import uart_pkg::*;
#(
    parameter int UPPER = 0
) (
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    always_comb ascii = (nib < 4'd10) ? ASC_0 + {4'h0, nib}
                                      : ((UPPER != 0) ? ASC_UA : ASC_LA) + {4'h0, nib} - 8'd10;

endmodule

// File: rtl/uart_hex_stream.sv
// uart_hex_stream: prints a captured word as ASCII hex bytes to an external UART.
// Define UART_HEX_CRLF_EN to end each message with CR LF instead of LF alone.
module uart_hex_stream
    import uart_pkg::*;
#(
    parameter int          DATA_W    = 256,
    parameter int          GROUP_NIB = 0,
    parameter int          UPPER     = 0,
    parameter int unsigned CHAR_GAP  = 1000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_done
);

    localparam int NIBS = DATA_W / 4;
    localparam int GE   = (GROUP_NIB > 0 && GROUP_NIB < NIBS) ? GROUP_NIB : 0;
`ifdef UART_HEX_CRLF_EN
    localparam int TERM = 2;
`else
    localparam int TERM = 1;
`endif
    localparam int TOTAL = NIBS + ((GE > 0) ? (NIBS - 1) / GE : 0) + TERM;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int NW    = $clog2(NIBS + 1);
    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [NW-1:0] NIB_END = NW'(NIBS);
    localparam logic [NW-1:0] GRP     = NW'(GE);

    state_t            state, nxt;
    logic [DATA_W-1:0] shadow;
    logic [NW-1:0]     nib_cnt, grp_cnt;
    logic              space_due;
    logic [CW-1:0]     char_idx;
    logic [31:0]       gap_cnt;
    logic [7:0]        nib_char, term_char, next_byte;

    hex_to_ascii #(.UPPER(UPPER)) u_hex (
        .nib  (shadow[DATA_W-1 -: 4]),
        .ascii(nib_char)
    );

    // The shadow shifts left per printed nibble, so the next digit is always on top.
    always_comb begin
`ifdef UART_HEX_CRLF_EN
        term_char = (char_idx == CW'(TOTAL - 2)) ? ASC_CR : ASC_LF;
`else
        term_char = ASC_LF;
`endif
        next_byte = space_due ? ASC_SP : (nib_cnt == NIB_END) ? term_char : nib_char;
    end

    always_comb begin
        nxt  = state;
        busy = state inside {LOAD, SEND, GAP};
        done = state == DONE;
        tx_en = state == SEND;
        case (state)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = tx_done ? LOAD : SEND;
            SEND:    nxt = !tx_done ? SEND : (char_idx == LAST) ? DONE : (CHAR_GAP == 0) ? LOAD : GAP;
            GAP:     nxt = (gap_cnt == CHAR_GAP - 1) ? LOAD : GAP;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            shadow    <= '0;
            nib_cnt   <= '0;
            grp_cnt   <= '0;
            space_due <= 1'b0;
            char_idx  <= '0;
            gap_cnt   <= '0;
            tx_data   <= 8'h00;
        end else begin
            state   <= nxt;
            gap_cnt <= (state == GAP && nxt == GAP) ? gap_cnt + 32'd1 : '0;
            if (state == IDLE && start) begin
                shadow    <= data_in;
                nib_cnt   <= '0;
                grp_cnt   <= '0;
                space_due <= 1'b0;
                char_idx  <= '0;
            end
            if (state == LOAD && !tx_done)
                tx_data <= next_byte;
            if (state == SEND && tx_done) begin
                char_idx <= char_idx + 1'b1;
                if (space_due) begin
                    space_due <= 1'b0;
                    grp_cnt   <= '0;
                end else if (nib_cnt != NIB_END) begin
                    shadow    <= shadow << 4;
                    nib_cnt   <= nib_cnt + 1'b1;
                    grp_cnt   <= grp_cnt + 1'b1;
                    space_due <= (GE > 0) && (grp_cnt + 1'b1 == GRP) && (nib_cnt + 1'b1 != NIB_END);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_hex_stream.sv
// tb_uart_hex_stream: three streamer configurations checked against a string-based message model.
module tb_uart_hex_stream;

    localparam int NI = 3;
    localparam int DW [NI] = '{16, 16, 8};
    localparam int GN [NI] = '{0, 2, 0};
    localparam int UP [NI] = '{0, 1, 0};
    localparam int CG [NI] = '{3, 3, 5};
`ifdef UART_HEX_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    function automatic void chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic logic [63:0] with_term(input logic [63:0] body);
        return CRLF ? {body[47:0], 16'h0D0A} : {body[55:0], 8'h0A};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_d
        logic              start = 1'b0;
        logic [DW[g]-1:0]  data_in = '0;
        logic              busy, done, tx_en;
        logic              tx_done = 1'b0;
        logic              hold = 1'b0;
        logic [7:0]        tx_data;
        logic [7:0]        exp_q [$];
        logic [7:0]        e;
        logic [7:0]        p_data = 8'h00;
        logic [63:0]       rx_val = '0;
        bit                p_en = 1'b0, p_done = 1'b0, first = 1'b1;
        int                rx_n = 0, done_n = 0, idle = 0, cnt = 0;

        uart_hex_stream #(
            .DATA_W(DW[g]), .GROUP_NIB(GN[g]), .UPPER(UP[g]), .CHAR_GAP(CG[g])
        ) dut (
            .Clk(Clk), .Rst(Rst), .start(start), .data_in(data_in), .busy(busy), .done(done),
            .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done)
        );

        // Expected message: hex text of the word, spaces between groups, then terminator.
        function automatic void push_msg(input logic [DW[g]-1:0] d);
            string s;
            s = $sformatf("%h", d);
            if (UP[g] != 0) s = s.toupper();
            for (int i = 0; i < s.len(); i++) begin
                exp_q.push_back(s[i]);
                if (GN[g] > 0 && (i + 1) % GN[g] == 0 && i + 1 < s.len()) exp_q.push_back(8'h20);
            end
            if (CRLF) exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        endfunction

        function automatic void idle_chk(input string nm);
            chk(!busy, {nm, "_busy"}, busy, 0);
            chk(!done, {nm, "_done"}, done, 0);
            chk(!tx_en, {nm, "_tx_en"}, tx_en, 0);
            chk(tx_data == 8'h00, {nm, "_tx_data"}, tx_data, 0);
        endfunction

        task automatic arm(input logic [DW[g]-1:0] d);
            push_msg(d);
            rx_val = '0;
            rx_n   = 0;
            done_n = 0;
        endtask

        task automatic pulse(input logic [DW[g]-1:0] d);
            data_in = d;
            start   = 1'b1;
            @(negedge Clk);
            start   = 1'b0;
        endtask

        task automatic wait_done();
            int i;
            i = 0;
            while (!done && i < 5000) begin
                @(negedge Clk);
                i++;
            end
            chk(done, "done_seen", done, 1);
            @(negedge Clk);
            chk(done_n == 1, "done_pulses", done_n, 1);
            chk(!busy && !done, "idle_after_done", {busy, done}, 0);
            chk(exp_q.size() == 0, "msg_complete", exp_q.size(), 0);
        endtask

        task automatic run(input logic [DW[g]-1:0] d);
            arm(d);
            pulse(d);
            chk(busy, "busy_after_start", busy, 1);
            wait_done();
        endtask

        // Per-cycle compare plus a UART stand-in that acknowledges 10 clocks after tx_en.
        always @(negedge Clk) begin
            if (tx_en && !p_en) begin
                rx_val = {rx_val[55:0], tx_data};
                rx_n++;
                if (exp_q.size() == 0) chk(1'b0, "extra_byte", tx_data, 0);
                else begin
                    e = exp_q.pop_front();
                    chk(tx_data == e, "byte", tx_data, e);
                end
                if (!first) chk(idle == CG[g] + 1, "char_gap", idle, CG[g] + 1);
                first = 1'b0;
            end
            if (tx_en && p_en) chk(tx_data == p_data, "tx_data_stable", tx_data, p_data);
            if (done) begin
                done_n++;
                chk(!busy, "busy_at_done", busy, 0);
                chk(!p_done, "done_width", 2, 1);
            end
            if (!busy) first = 1'b1;
            idle    = tx_en ? 0 : idle + 1;
            p_en    = tx_en;
            p_data  = tx_data;
            p_done  = done;
            tx_done = hold ? 1'b1 : !tx_en ? 1'b0 : (cnt == 9) ? 1'b1 : tx_done;
            cnt     = tx_en ? cnt + 1 : 0;
        end
    end

    initial begin
        repeat (3) @(negedge Clk);
        g_d[0].idle_chk("rst0");
        g_d[1].idle_chk("rst1");
        g_d[2].idle_chk("rst2");
        Rst = 1'b0;
        @(negedge Clk);

        g_d[0].run(16'hA8F3);
        chk(g_d[0].rx_val == with_term(64'h61_38_66_33), "lit_a8f3", g_d[0].rx_val, with_term(64'h61_38_66_33));
        chk(g_d[0].rx_n == 4 + int'(CRLF) + 1, "len_a8f3", g_d[0].rx_n, 5 + int'(CRLF));

        g_d[1].run(16'hA8F3);
        chk(g_d[1].rx_val == with_term(64'h41_38_20_46_33), "lit_A8_F3", g_d[1].rx_val, with_term(64'h41_38_20_46_33));
        g_d[1].run(16'h0B9C);
        chk(g_d[1].rx_val == with_term(64'h30_42_20_39_43), "lit_0B_9C", g_d[1].rx_val, with_term(64'h30_42_20_39_43));

        g_d[2].run(8'h00);
        chk(g_d[2].rx_val == with_term(64'h30_30), "lit_00", g_d[2].rx_val, with_term(64'h30_30));
        g_d[2].run(8'hE7);
        chk(g_d[2].rx_val == with_term(64'h65_37), "lit_e7", g_d[2].rx_val, with_term(64'h65_37));

        g_d[0].arm(16'h5555);
        g_d[0].pulse(16'h5555);
        for (int i = 0; i < 500 && g_d[0].rx_n < 3; i++) @(negedge Clk);
        chk(g_d[0].rx_n == 3 && g_d[0].tx_en, "third_in_send", g_d[0].rx_n, 3);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        g_d[0].idle_chk("mid_rst");
        g_d[0].exp_q.delete();
        g_d[0].run(16'h1234);
        chk(g_d[0].rx_val == with_term(64'h31_32_33_34), "lit_1234", g_d[0].rx_val, with_term(64'h31_32_33_34));

        g_d[0].hold = 1'b1;
        repeat (2) @(negedge Clk);
        g_d[0].arm(16'h00FF);
        g_d[0].pulse(16'h00FF);
        repeat (20) @(negedge Clk);
        chk(g_d[0].rx_n == 0 && !g_d[0].tx_en, "hold_no_tx", g_d[0].rx_n, 0);
        chk(g_d[0].busy, "hold_busy", g_d[0].busy, 1);
        g_d[0].pulse(16'hBEEF);
        g_d[0].hold = 1'b0;
        g_d[0].wait_done();
        chk(g_d[0].rx_val == with_term(64'h30_30_66_66), "lit_00ff", g_d[0].rx_val, with_term(64'h30_30_66_66));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_hex_stream.md
UART_HEX_STREAM -- requirements
Module: uart_hex_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 256, width of word to print; multiple of 4, range 4..512.
REQ-002 SHALL have parameter GROUP_NIB, default 0, nibbles per space-separated group; 0 = no spaces.
REQ-003 SHALL have parameter UPPER, default 0; 1 = 'A'-'F', 0 = 'a'-'f'.
REQ-004 SHALL have parameter CHAR_GAP, default 1000, idle clocks between bytes, 32-bit, 0 allowed.
REQ-005 SHALL have port Clk  input  1  system clock; one clock domain; all logic on rising edge.
REQ-006 SHALL have port Rst  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port start  input  1  one-cycle request to print data_in.
REQ-008 SHALL have port data_in  input  DATA_W  word to print, MS nibble first.
REQ-009 SHALL have port busy  output  1  high from accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse after last byte acknowledged.
REQ-011 SHALL have port tx_data  output  8  ASCII byte to UART transmitter.
REQ-012 SHALL have port tx_en  output  1  transmit request to UART transmitter.
REQ-013 SHALL have port tx_done  input  1  UART byte-complete strobe or level.

Function
REQ-014 SHALL, in IDLE with start=1, capture data_in into a shadow register, clear char index, set busy, enter LOAD; start while busy SHALL be ignored.
REQ-015 Byte sequence SHALL be: DATA_W/4 hex chars MS-first; a space (0x20) after every GROUP_NIB-th nibble except the last; then the terminator (REQ-026).
REQ-016 LOAD SHALL wait until tx_done=0, then register the next byte onto tx_data and enter SEND.
REQ-017 SEND SHALL hold tx_en=1 with tx_data stable until tx_done=1 is sampled.
REQ-018 On tx_done=1 in SEND, tx_en SHALL drop the next cycle; next state is DONE if the byte was the final terminator byte, else GAP.
REQ-019 GAP SHALL count CHAR_GAP clocks, then enter LOAD; CHAR_GAP=0 SHALL go directly to LOAD.
REQ-020 DONE SHALL pulse done for exactly one cycle, clear busy the same cycle, return to IDLE; a start in the following cycle SHALL be accepted.
REQ-021 Nibble n (0 = MS) SHALL map 0-9 to 0x30-0x39 and 10-15 to 0x61-0x66, or 0x41-0x46 when UPPER=1.
REQ-022 Char index counter SHALL be sized for the maximum total byte count; no wrap within a message.
REQ-023 Changes on data_in after capture SHALL NOT affect the current message.

Reset
REQ-024 Rst=1 at any clock, including mid-message, SHALL force IDLE, busy=0, done=0, tx_en=0, tx_data=0x00, and clear the gap counter and char index; no partial byte SHALL be re-requested.
REQ-025 Rst SHALL take precedence over a simultaneous start.

Configuration
REQ-026 Macro UART_HEX_CRLF_EN: defined -> terminator is 0x0D then 0x0A (two bytes); undefined -> terminator is 0x0A only.

Structure
REQ-027 State encoding (IDLE, LOAD, SEND, GAP, DONE) and the ASCII constants (0x20, 0x0A, 0x0D, '0', 'a', 'A') SHALL live in shared package uart_pkg.
REQ-028 Nibble-to-ASCII conversion SHALL be a sub-module, hex_to_ascii (4-bit in, UPPER parameter, 8-bit out, combinational).
REQ-029 The block SHALL NOT instantiate the UART transmitter or the baud generator; it connects to existing ones at top level.

Verification
REQ-030 DATA_W=16, start with 0xA8F3, tx_done model 10 clocks after tx_en -> bytes 0x61,0x38,0x66,0x33,0x0A; one done pulse; busy low afterwards.
REQ-031 Same stimulus with UPPER=1, GROUP_NIB=2 -> "A8 F3\n": 0x41,0x38,0x20,0x46,0x33,0x0A.
REQ-032 UART_HEX_CRLF_EN defined, DATA_W=8, data 0x00 -> 0x30,0x30,0x0D,0x0A; CHAR_GAP=5 -> at least 5 idle clocks between tx_en falling and the next tx_en rising.
REQ-033 Rst asserted while the third byte is in SEND -> next cycle tx_en=0, busy=0; a new start with 0x1234 prints "1234\n" from the first nibble.
REQ-034 tx_done held at 1 when start arrives -> tx_en stays 0 until tx_done=0; a second start pulse while busy -> exactly one message emitted.
